// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA timing receiver: line/frame measurement, lock FSM, pixel coordinate recovery
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 521,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 29,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iHsync,
    input  logic       iVsync,
    input  logic [2:0] iVGA_RGB,
    output logic [2:0] oRGB,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oPixelValid,
    output logic       oLocked,
    output logic       oSyncErr,
    output logic [9:0] oLinePeriod,
    output logic [9:0] oFrameLines
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [9:0] CNT_MAX    = 10'h3ff;
    localparam logic [9:0] H_TOTAL_V  = 10'(H_TOTAL);
    localparam logic [9:0] H_SYNC_V   = 10'(H_SYNC);
    localparam logic [9:0] H_ACTIVE_V = 10'(H_ACTIVE);
    localparam logic [9:0] V_TOTAL_V  = 10'(V_TOTAL);
    localparam logic [9:0] V_SYNC_V   = 10'(V_SYNC);
    localparam logic [9:0] V_ACTIVE_V = 10'(V_ACTIVE);
    localparam logic [9:0] X_OFF      = 10'(H_SYNC + H_BP);
    localparam logic [9:0] Y_OFF      = 10'(V_SYNC + V_BP);
    localparam logic [3:0] LOCK_N     = 4'(LOCK_FRAMES);

    logic       s_hs, s_vs, s_hs_d, s_vs_d;
    logic [2:0] s_rgb, rgb_d;
    logic [9:0] h_cnt, v_cnt, hs_width, vs_width;
    logic       hs_ok, lines_ok;
    state_t     state, state_next;
    logic [3:0] good_cnt, good_next;
    logic       err_next;
    logic       hs_fall, hs_rise, vs_fall, timeout;
    logic       line_good, bad_line, frame_good, sync_fault;
    logic [9:0] line_period, frame_lines, x_raw, y_raw;
    logic       x_in, y_in;
    logic       pv_p;
    logic [9:0] x_p, y_p;
    logic [2:0] rgb_p;

    assign hs_fall     = s_hs_d & ~s_hs;
    assign hs_rise     = ~s_hs_d & s_hs;
    assign vs_fall     = s_vs_d & ~s_vs;
    assign timeout     = (h_cnt == CNT_MAX);
    assign line_period = timeout ? CNT_MAX : h_cnt + 10'd1;
    assign line_good   = (line_period == H_TOTAL_V) && hs_ok;
    assign bad_line    = hs_fall && !line_good;
    // The line closed by a coincident hsync fall still belongs to the frame ending here.
    assign frame_lines = v_cnt + {9'd0, hs_fall};
    assign frame_good  = (frame_lines == V_TOTAL_V) && (vs_width == V_SYNC_V) &&
                         lines_ok && (!hs_fall || line_good);
    assign sync_fault  = timeout || bad_line || (vs_fall && !frame_good);
    // Underflowed raw coordinates are rejected by the lower-bound compare.
    assign x_raw       = h_cnt - X_OFF;
    assign y_raw       = v_cnt - Y_OFF;
    assign x_in        = (h_cnt >= X_OFF) && (x_raw < H_ACTIVE_V);
    assign y_in        = (v_cnt >= Y_OFF) && (y_raw < V_ACTIVE_V);

    // Input registers and edge-detect delay stage; RGB is delayed to line up with the decode stage.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s_hs   <= 1'b0;
            s_vs   <= 1'b0;
            s_hs_d <= 1'b0;
            s_vs_d <= 1'b0;
            s_rgb  <= 3'd0;
            rgb_d  <= 3'd0;
        end else begin
            s_hs   <= iHsync;
            s_vs   <= iVsync;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            s_rgb  <= iVGA_RGB;
            rgb_d  <= s_rgb;
        end
    end

    // Horizontal position, line period and hsync pulse width measurement.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            h_cnt       <= 10'd0;
            oLinePeriod <= 10'd0;
            hs_width    <= 10'd0;
            hs_ok       <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt       <= 10'd0;
                oLinePeriod <= line_period;
            end else if (!timeout) begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (hs_fall)
                hs_width <= 10'd1;
            else if (!s_hs && hs_width != CNT_MAX)
                hs_width <= hs_width + 10'd1;
            if (hs_rise)
                hs_ok <= (hs_width == H_SYNC_V);
        end
    end

    // Vertical position, frame length, vsync width in lines and per-frame line health.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            v_cnt       <= 10'd0;
            oFrameLines <= 10'd0;
            vs_width    <= 10'd0;
            lines_ok    <= 1'b0;
        end else begin
            if (vs_fall) begin
                v_cnt       <= 10'd0;
                oFrameLines <= frame_lines;
                vs_width    <= {9'd0, hs_fall};
                lines_ok    <= 1'b1;
            end else begin
                if (hs_fall && v_cnt != CNT_MAX)
                    v_cnt <= v_cnt + 10'd1;
                if (hs_fall && !s_vs)
                    vs_width <= vs_width + 10'd1;
                if (bad_line)
                    lines_ok <= 1'b0;
            end
        end
    end

    // Lock state register with registered lock and sticky error flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= SEARCH;
            good_cnt <= 4'd0;
            oLocked  <= 1'b0;
            oSyncErr <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            oLocked  <= (state_next == LOCKED);
            oSyncErr <= err_next;
        end
    end

    // Next-state logic: count good frames to lock, drop to SEARCH on any timing fault.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = oSyncErr;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_next = ACQUIRE;
                    good_next  = 4'd0;
                end
            end
            ACQUIRE: begin
                if (sync_fault) begin
                    state_next = SEARCH;
                end else if (vs_fall) begin
                    good_next = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LOCK_N)
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (sync_fault) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Decode stage: window test on the current counters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pv_p  <= 1'b0;
            x_p   <= 10'd0;
            y_p   <= 10'd0;
            rgb_p <= 3'd0;
        end else if ((state == LOCKED) && x_in && y_in) begin
            pv_p  <= 1'b1;
            x_p   <= x_raw;
            y_p   <= y_raw;
            rgb_p <= rgb_d;
        end else begin
            pv_p  <= 1'b0;
            x_p   <= 10'd0;
            y_p   <= 10'd0;
            rgb_p <= 3'd0;
        end
    end

    // Output register, three edges after the input sample.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oPixelValid <= 1'b0;
            oX          <= 10'd0;
            oY          <= 10'd0;
            oRGB        <= 3'd0;
        end else begin
            oPixelValid <= pv_p;
            oX          <= x_p;
            oY          <= y_p;
            oRGB        <= rgb_p;
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver using a reduced timing mode
module tb_vga_sync_receiver;

    localparam int HT = 24;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HA = 12;
    localparam int VT = 12;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 6;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iHsync, iVsync;
    logic [2:0] iVGA_RGB;
    logic [2:0] oRGB;
    logic [9:0] oX, oY, oLinePeriod, oFrameLines;
    logic       oPixelValid, oLocked, oSyncErr;

    int tests = 0;
    int fails = 0;
    int pat_mode = 0;
    int valid_total = 0, rgb_err = 0, idle_err = 0, range_err = 0, idle_run = 0;
    int v0;
    logic [9:0] first_x = 10'd0, first_y = 10'd0, last_x = 10'd0, last_y = 10'd0;
    logic [2:0] first_rgb = 3'd0, last_rgb = 3'd0;

    always #5 Clock = ~Clock;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iHsync(iHsync), .iVsync(iVsync),
        .iVGA_RGB(iVGA_RGB), .oRGB(oRGB), .oX(oX), .oY(oY),
        .oPixelValid(oPixelValid), .oLocked(oLocked), .oSyncErr(oSyncErr),
        .oLinePeriod(oLinePeriod), .oFrameLines(oFrameLines)
    );

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pixel monitor: per-cycle statistics on the recovered stream.
    always @(negedge Clock) begin
        if (oPixelValid) begin
            valid_total++;
            if (idle_run > HT) begin
                first_x   = oX;
                first_y   = oY;
                first_rgb = oRGB;
            end
            idle_run = 0;
            last_x   = oX;
            last_y   = oY;
            last_rgb = oRGB;
            if (oRGB != ((pat_mode != 0) ? oX[2:0] : 3'b010)) rgb_err++;
            if (oX >= 10'(HA) || oY >= 10'(VA)) range_err++;
        end else begin
            idle_run++;
            if (oX != 10'd0 || oY != 10'd0 || oRGB != 3'd0) idle_err++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            iHsync   = 1'b1;
            iVsync   = 1'b1;
            iVGA_RGB = 3'd0;
        end
    endtask

    // One frame; optionally one long line, one short hsync pulse, or a one-cycle reset in an active line.
    task automatic send_frame(input int long_line, input int short_line, input int rst_line);
        int len, hsw;
        for (int l = 0; l < VT; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            hsw = (l == short_line) ? HS - 1 : HS;
            for (int c = 0; c < len; c++) begin
                @(negedge Clock);
                if (l == rst_line && c == 12) begin
                    check_eq("rst_locked_before", oLocked, 1);
                    check_eq("rst_valid_before", oPixelValid, 1);
                end
                if (l == rst_line && c == 13) begin
                    check_eq("rst_locked_after", oLocked, 0);
                    check_eq("rst_outputs_after",
                             {oRGB, oX, oY, oPixelValid, oSyncErr, oLinePeriod, oFrameLines}, 0);
                end
                iHsync = (c < hsw) ? 1'b0 : 1'b1;
                iVsync = (l < VS) ? 1'b0 : 1'b1;
                if (l >= VS + VB && l < VS + VB + VA && c >= HS + HB && c < HS + HB + HA)
                    iVGA_RGB = (pat_mode != 0) ? 3'(c - HS - HB) : 3'b010;
                else
                    iVGA_RGB = 3'd0;
                Reset = (l == rst_line && c == 12);
            end
        end
    endtask

    initial begin
        Reset    = 1'b1;
        iHsync   = 1'b1;
        iVsync   = 1'b1;
        iVGA_RGB = 3'd0;
        repeat (3) @(negedge Clock);
        check_eq("reset_outputs",
                 {oRGB, oX, oY, oPixelValid, oLocked, oSyncErr, oLinePeriod, oFrameLines}, 0);
        Reset = 1'b0;
        idle(4);

        // Clean lock: third vsync fall after reset locks.
        send_frame(-1, -1, -1);
        send_frame(-1, -1, -1);
        check_eq("no_lock_before_3rd_vs", oLocked, 0);
        send_frame(-1, -1, -1);
        check_eq("lock_at_3rd_vs", oLocked, 1);
        check_eq("line_period", oLinePeriod, HT);
        check_eq("frame_lines", oFrameLines, VT);
        check_eq("sync_err_clean", oSyncErr, 0);

        // Active window with constant colour.
        v0 = valid_total;
        send_frame(-1, -1, -1);
        check_eq("valid_count_solid", valid_total - v0, HA * VA);
        check_eq("first_x", first_x, 0);
        check_eq("first_y", first_y, 0);
        check_eq("first_rgb", first_rgb, 3'b010);
        check_eq("last_x", last_x, HA - 1);
        check_eq("last_y", last_y, VA - 1);
        check_eq("last_rgb", last_rgb, 3'b010);

        // Column-coded colour checks RGB alignment on every pixel.
        pat_mode = 1;
        v0 = valid_total;
        send_frame(-1, -1, -1);
        check_eq("valid_count_ramp", valid_total - v0, HA * VA);
        check_eq("rgb_ramp_err", rgb_err, 0);
        pat_mode = 0;

        // Reset mid-frame, then a short hsync pulse while acquiring.
        send_frame(-1, -1, 5);
        send_frame(-1, 3, -1);
        check_eq("short_hs_no_lock", oLocked, 0);
        send_frame(-1, -1, -1);
        send_frame(-1, -1, -1);
        check_eq("short_hs_relock_early", oLocked, 0);
        send_frame(-1, -1, -1);
        check_eq("short_hs_relock", oLocked, 1);
        check_eq("short_hs_sync_err", oSyncErr, 0);

        // One line a clock too long while locked.
        send_frame(10, -1, -1);
        check_eq("long_line_period", oLinePeriod, HT + 1);
        check_eq("long_line_unlock", oLocked, 0);
        check_eq("long_line_sync_err", oSyncErr, 1);
        send_frame(-1, -1, -1);
        send_frame(-1, -1, -1);
        check_eq("long_relock_early", oLocked, 0);
        send_frame(-1, -1, -1);
        check_eq("long_relock", oLocked, 1);
        check_eq("long_err_sticky", oSyncErr, 1);
        check_eq("long_period_restored", oLinePeriod, HT);

        // Missing hsync: lock held until the horizontal counter saturates.
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_eq("reset_clears_err", oSyncErr, 0);
        idle(4);
        repeat (3) send_frame(-1, -1, -1);
        check_eq("to_locked", oLocked, 1);
        idle(500);
        check_eq("to_not_yet", oLocked, 1);
        idle(600);
        check_eq("to_unlock", oLocked, 0);
        check_eq("to_sync_err", oSyncErr, 1);
        check_eq("to_pixel_valid", oPixelValid, 0);

        check_eq("idle_outputs_err", idle_err, 0);
        check_eq("coord_range_err", range_err, 0);
        check_eq("rgb_err_total", rgb_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
